// File: rtl/hazard_scoreboard.sv
// Issue-control scoreboard: per-register pending-write counters, a jump counter and an in-flight limit.
// Define SCOREBOARD_STATS_EN to add the stall_cycles / stall_hazard_cycles statistics outputs.
module hazard_scoreboard #(
    parameter int NUM_REGS     = 32,
    parameter int REG_BITS     = 5,
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_BITS     = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic [REG_BITS-1:0] issue_rd,
    input  logic                issue_wb,
    input  logic                issue_jmp,
    input  logic [NUM_REGS-1:0] issue_src_mask,
    output logic                issue_ready,
    input  logic                retire_valid,
    input  logic [REG_BITS-1:0] retire_rd,
    input  logic                retire_wb,
    input  logic                retire_jmp,
    input  logic                flush,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic                jmp_busy,
    output logic [CNT_BITS-1:0] inflight,
    output logic                err
`ifdef SCOREBOARD_STATS_EN
    ,
    output logic [31:0]         stall_cycles,
    output logic [31:0]         stall_hazard_cycles
`endif
);

    localparam logic [CNT_BITS-1:0] MAX_CNT = CNT_BITS'(MAX_INFLIGHT);

    // Returns {underflow, next}. Opposing +1/-1 cancel; a lone -1 at zero holds zero and flags underflow.
    function automatic logic [CNT_BITS:0] step_cnt(input logic [CNT_BITS-1:0] cur,
                                                   input logic inc, input logic dec);
        logic [CNT_BITS:0] res;
        res = {1'b0, cur};
        if (inc && !dec) begin
            res = {1'b0, cur + CNT_BITS'(1)};
        end else if (dec && !inc) begin
            if (cur == '0) res = {1'b1, cur};
            else           res = {1'b0, cur - CNT_BITS'(1)};
        end
        return res;
    endfunction

    logic [CNT_BITS-1:0] icnt_q, icnt_d, jcnt_q, jcnt_d;
    logic                icnt_under, jcnt_under;
    logic [CNT_BITS-1:0] icnt_step, jcnt_step;
    logic                err_q, err_d;

    logic [NUM_REGS-1:0] issue_hit, retire_hit, reg_full, reg_under;
    logic                hazard, rd_full, issue_fire, retire_fire;

    assign issue_hit[0]  = 1'b0;
    assign retire_hit[0] = 1'b0;
    assign reg_full[0]   = 1'b0;
    assign reg_under[0]  = 1'b0;
    assign busy_mask[0]  = 1'b0;

    // Register 0 is never tracked; indices at or above NUM_REGS never match any slot.
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
        logic [CNT_BITS-1:0] cnt_q, cnt_d;
        logic [CNT_BITS:0]   stepped;

        assign issue_hit[gi]  = issue_wb  && (issue_rd  == REG_BITS'(gi));
        assign retire_hit[gi] = retire_wb && (retire_rd == REG_BITS'(gi));
        assign stepped        = step_cnt(cnt_q, issue_fire && issue_hit[gi],
                                         retire_fire && retire_hit[gi]);
        assign reg_under[gi]  = stepped[CNT_BITS];
        assign reg_full[gi]   = (cnt_q == MAX_CNT);
        assign busy_mask[gi]  = (cnt_q != '0);

        always_comb begin
            cnt_d = stepped[CNT_BITS-1:0];
            if (flush) cnt_d = '0;
        end

        always_ff @(posedge clk) begin
            if (rst) cnt_q <= '0;
            else     cnt_q <= cnt_d;
        end
    end

    assign hazard   = |(issue_src_mask & busy_mask);
    assign rd_full  = |(issue_hit & reg_full);
    assign jmp_busy = (jcnt_q != '0);
    assign inflight = icnt_q;
    assign err      = err_q;

    // No same-cycle retire bypass: readiness looks only at registered state.
    assign issue_ready = !flush && !hazard && !jmp_busy && (icnt_q != MAX_CNT) && !rd_full;
    assign issue_fire  = issue_valid && issue_ready;
    assign retire_fire = retire_valid && !flush;

    assign {icnt_under, icnt_step} = step_cnt(icnt_q, issue_fire, retire_fire);
    assign {jcnt_under, jcnt_step} = step_cnt(jcnt_q, issue_fire && issue_jmp,
                                              retire_fire && retire_jmp);

    always_comb begin
        icnt_d = icnt_step;
        jcnt_d = jcnt_step;
        err_d  = err_q | icnt_under | jcnt_under | (|reg_under);
        if (flush) begin
            icnt_d = '0;
            jcnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            icnt_q <= '0;
            jcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            icnt_q <= icnt_d;
            jcnt_q <= jcnt_d;
            err_q  <= err_d;
        end
    end

`ifdef SCOREBOARD_STATS_EN
    logic [31:0] stall_q, stall_d, stall_haz_q, stall_haz_d;
    logic        stall;

    assign stall = issue_valid && !issue_ready && !flush;

    always_comb begin
        stall_d     = stall_q;
        stall_haz_d = stall_haz_q;
        if (stall)           stall_d     = stall_q + 32'd1;
        if (stall && hazard) stall_haz_d = stall_haz_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q     <= '0;
            stall_haz_q <= '0;
        end else begin
            stall_q     <= stall_d;
            stall_haz_q <= stall_haz_d;
        end
    end

    assign stall_cycles        = stall_q;
    assign stall_hazard_cycles = stall_haz_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed and randomized checks of hazard_scoreboard against an in-flight-queue reference model.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_wb;
    logic        issue_jmp;
    logic [31:0] issue_src_mask;
    logic        issue_ready;
    logic        retire_valid;
    logic [4:0]  retire_rd;
    logic        retire_wb;
    logic        retire_jmp;
    logic        flush;
    logic [31:0] busy_mask;
    logic        jmp_busy;
    logic [2:0]  inflight;
    logic        err;
`ifdef SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] stall_hazard_cycles;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        int rd;
        bit wb;
        bit jmp;
    } ins_t;
    ins_t q[$];

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_wb(issue_wb),
        .issue_jmp(issue_jmp), .issue_src_mask(issue_src_mask), .issue_ready(issue_ready),
        .retire_valid(retire_valid), .retire_rd(retire_rd), .retire_wb(retire_wb),
        .retire_jmp(retire_jmp), .flush(flush),
        .busy_mask(busy_mask), .jmp_busy(jmp_busy), .inflight(inflight), .err(err)
`ifdef SCOREBOARD_STATS_EN
        , .stall_cycles(stall_cycles), .stall_hazard_cycles(stall_hazard_cycles)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; issue_rd = 0; issue_wb = 0; issue_jmp = 0; issue_src_mask = 0;
        retire_valid = 0; retire_rd = 0; retire_wb = 0; retire_jmp = 0; flush = 0;
    endtask

    task automatic set_issue(input int rd, input bit wb, input bit jmp, input logic [31:0] src);
        issue_valid = 1; issue_rd = 5'(rd); issue_wb = wb; issue_jmp = jmp; issue_src_mask = src;
    endtask

    task automatic set_retire(input int rd, input bit wb, input bit jmp);
        retire_valid = 1; retire_rd = 5'(rd); retire_wb = wb; retire_jmp = jmp;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick(); tick();
        rst = 0;
    endtask

    // Number of pending writes to register r among the in-flight instructions.
    function automatic int writes_to(input int r);
        int n = 0;
        foreach (q[k]) if (q[k].wb && q[k].rd == r && r != 0) n++;
        return n;
    endfunction

    function automatic int jumps_pending();
        int n = 0;
        foreach (q[k]) if (q[k].jmp) n++;
        return n;
    endfunction

    function automatic logic [31:0] model_busy();
        logic [31:0] m = 0;
        for (int r = 1; r < 32; r++) if (writes_to(r) > 0) m[r] = 1'b1;
        return m;
    endfunction

    function automatic bit model_ready(input int rd, input bit wb, input logic [31:0] src);
        if ((src & model_busy()) != 0) return 0;
        if (jumps_pending() > 0) return 0;
        if (q.size() == 4) return 0;
        if (wb && rd != 0 && writes_to(rd) == 4) return 0;
        return 1;
    endfunction

    initial begin
        idle();
        rst = 1;
        do_reset();

        // Reset state
        check("rst_busy", 64'(busy_mask), 64'(0));
        check("rst_jmp", 64'(jmp_busy), 64'(0));
        check("rst_inflight", 64'(inflight), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_ready", 64'(issue_ready), 64'(1));

        // Single write then dependent read
        set_issue(5, 1, 0, 0); tick(); idle();
        check("t1_busy", 64'(busy_mask), 64'(32'h20));
        check("t1_inflight", 64'(inflight), 64'(1));
        set_issue(0, 0, 0, 32'h20); #1;
        check("t1_hazard_ready", 64'(issue_ready), 64'(0));
        idle(); set_retire(5, 1, 0); tick(); idle();
        check("t1_busy_clr", 64'(busy_mask), 64'(0));
        set_issue(0, 0, 0, 32'h20); #1;
        check("t1_ready_again", 64'(issue_ready), 64'(1));
        idle();

        // Fill in-flight limit with writes to r3
        for (int i = 0; i < 4; i++) begin
            set_issue(3, 1, 0, 0); #1;
            check($sformatf("t2_fill_ready%0d", i), 64'(issue_ready), 64'(1));
            tick();
        end
        idle();
        check("t2_inflight", 64'(inflight), 64'(4));
        check("t2_busy", 64'(busy_mask), 64'(32'h8));
        set_issue(7, 1, 0, 0); #1;
        check("t2_full_ready", 64'(issue_ready), 64'(0));
        idle(); set_retire(3, 1, 0); tick(); idle();
        set_issue(7, 1, 0, 0); #1;
        check("t2_one_retired_ready", 64'(issue_ready), 64'(1));
        check("t2_still_busy", 64'(busy_mask), 64'(32'h8));
        idle();
        for (int i = 0; i < 3; i++) begin
            set_retire(3, 1, 0); tick(); idle();
        end
        check("t2_drained_busy", 64'(busy_mask), 64'(0));
        check("t2_drained_inflight", 64'(inflight), 64'(0));

        // Jump blocks all issue
        set_issue(0, 0, 1, 0); tick(); idle();
        check("t3_jmp_busy", 64'(jmp_busy), 64'(1));
        set_issue(1, 1, 0, 0); #1;
        check("t3_ready_blocked", 64'(issue_ready), 64'(0));
        idle(); set_retire(0, 0, 1); tick(); idle();
        check("t3_jmp_clear", 64'(jmp_busy), 64'(0));
        set_issue(1, 1, 0, 0); #1;
        check("t3_ready_again", 64'(issue_ready), 64'(1));
        idle();

        // Simultaneous issue and retire on the same register
        set_issue(9, 1, 0, 0); tick(); idle();
        set_issue(9, 1, 0, 0); set_retire(9, 1, 0); #1;
        check("t4_ready", 64'(issue_ready), 64'(1));
        tick(); idle();
        check("t4_busy", 64'(busy_mask), 64'(32'h200));
        check("t4_inflight", 64'(inflight), 64'(1));
        set_retire(9, 1, 0); tick(); idle();
        check("t4_clean", 64'(busy_mask), 64'(0));

        // Underflow, then flush with concurrent issue, then reset clears err
        set_retire(12, 1, 0); tick(); idle();
        check("t5_err", 64'(err), 64'(1));
        check("t5_busy", 64'(busy_mask), 64'(0));
        check("t5_inflight", 64'(inflight), 64'(0));
        for (int i = 1; i <= 3; i++) begin
            set_issue(i, 1, 0, 0); tick(); idle();
        end
        check("t5_inflight3", 64'(inflight), 64'(3));
        set_issue(4, 1, 0, 0); set_retire(1, 1, 0); flush = 1; #1;
        check("t5_flush_ready", 64'(issue_ready), 64'(0));
        tick(); idle();
        check("t5_flush_busy", 64'(busy_mask), 64'(0));
        check("t5_flush_inflight", 64'(inflight), 64'(0));
        check("t5_flush_err", 64'(err), 64'(1));
        do_reset();
        check("t5_rst_err", 64'(err), 64'(0));

`ifdef SCOREBOARD_STATS_EN
        // Stall statistics: 6 hazard stalls then 2 jump stalls
        check("t6_stall_rst", 64'(stall_cycles), 64'(0));
        set_issue(5, 1, 0, 0); tick(); idle();
        set_issue(0, 0, 0, 32'h20);
        for (int i = 0; i < 6; i++) tick();
        idle();
        check("t6_stall", 64'(stall_cycles), 64'(6));
        check("t6_stall_haz", 64'(stall_hazard_cycles), 64'(6));
        set_retire(5, 1, 0); tick(); idle();
        set_issue(0, 0, 1, 0); tick(); idle();
        set_issue(2, 1, 0, 0); tick(); tick(); idle();
        check("t6_stall_jmp", 64'(stall_cycles), 64'(8));
        check("t6_stall_haz_jmp", 64'(stall_hazard_cycles), 64'(6));
`endif

        // Randomized traffic against the in-flight queue model
        do_reset();
        q.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            int rd;
            bit wb, jmp, iv, rv, fl, exp_ready;
            logic [31:0] src;
            ins_t ni, ri;
            rd  = $urandom_range(0, 7);
            wb  = ($urandom_range(0, 3) != 0);
            jmp = ($urandom_range(0, 7) == 0);
            iv  = $urandom_range(0, 1) == 1;
            src = ($urandom_range(0, 2) == 0) ? (32'd1 << $urandom_range(0, 7)) : 32'd0;
            rv  = (q.size() > 0) && ($urandom_range(0, 2) != 0);
            fl  = ($urandom_range(0, 31) == 0);
            idle();
            if (iv) set_issue(rd, wb, jmp, src);
            else issue_src_mask = src;
            if (rv) begin
                ri = q[0];
                set_retire(ri.rd, ri.wb, ri.jmp);
            end
            flush = fl;
            #1;
            exp_ready = !fl && model_ready(rd, wb, src);
            // With issue_valid low, rd/wb are driven as zero.
            if (!iv) exp_ready = !fl && model_ready(0, 0, src);
            check($sformatf("rnd%0d_ready", cyc), 64'(issue_ready), 64'(exp_ready));
            if (fl) q.delete();
            else begin
                if (rv) void'(q.pop_front());
                if (iv && exp_ready) begin
                    ni.rd = rd; ni.wb = wb; ni.jmp = jmp;
                    q.push_back(ni);
                end
            end
            tick();
            check($sformatf("rnd%0d_busy", cyc), 64'(busy_mask), 64'(model_busy()));
            check($sformatf("rnd%0d_jmp", cyc), 64'(jmp_busy), 64'(jumps_pending() > 0));
            check($sformatf("rnd%0d_inflight", cyc), 64'(inflight), 64'(q.size()));
            check($sformatf("rnd%0d_err", cyc), 64'(err), 64'(0));
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
